alu_uart_ctrl: RTL and testbench
================================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the ALU operand/result width; legal range 1..8.
REQ-002 The block SHALL have parameter NSel, default 6, meaning the ALU opcode width.
REQ-003 The block SHALL have parameter ALU_LAT, default 1, meaning the clock cycles from operands stable to ALU result valid.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- i_clock  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have these data and handshake ports:
- i_rx_data  in  8  received UART byte.
- i_rx_done  in  1  one-cycle pulse; i_rx_data valid this cycle.
- o_alu_A  out  N  registered operand A to the ALU.
- o_alu_B  out  N  registered operand B to the ALU.
- o_alu_Op  out  NSel  registered opcode to the ALU.
- i_alu_Result  in  N  ALU result.
- i_ovf_flag  in  1  ALU overflow flag.
- i_zero_flag  in  1  ALU zero flag.
- o_tx_data  out  8  byte to the UART transmitter.
- o_tx_start  out  1  one-cycle pulse; starts transmission of o_tx_data.
- i_tx_done  in  1  one-cycle pulse; transmitter finished its byte.
- o_busy  out  1  high in every state except RX_A.
- o_drop  out  1  one-cycle pulse; the received byte was discarded.

Function
REQ-006 The FSM states SHALL be RX_A, RX_B, RX_OP, EXEC, TX_RES, WAIT_RES, TX_FLG and WAIT_FLG.
REQ-007 In RX_A, i_rx_done SHALL load o_alu_A from i_rx_data[N-1:0] and move the FSM to RX_B.
REQ-008 In RX_B, i_rx_done SHALL load o_alu_B from i_rx_data[N-1:0] and move the FSM to RX_OP.
REQ-009 In RX_OP, a byte with bits [7:6]=00 and bits [5:0] in {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111} SHALL load o_alu_Op and move the FSM to EXEC.
REQ-010 In RX_OP, any other byte SHALL pulse o_drop for one cycle and keep the FSM in RX_OP, with o_alu_Op unchanged.
REQ-011 EXEC SHALL count ALU_LAT+1 cycles, then capture i_alu_Result, i_ovf_flag and i_zero_flag into internal registers and move the FSM to TX_RES.
REQ-012 TX_RES SHALL drive o_tx_data = zero-extended captured result, pulse o_tx_start for exactly one cycle, and move the FSM to WAIT_RES.
REQ-013 WAIT_RES SHALL hold o_tx_data until i_tx_done, then move the FSM to TX_FLG.
REQ-014 TX_FLG SHALL drive o_tx_data = {6'b0, ovf, zero} from the captured values, pulse o_tx_start for one cycle, and move the FSM to WAIT_FLG.
REQ-015 WAIT_FLG SHALL hold o_tx_data until i_tx_done, then return the FSM to RX_A.
REQ-016 o_alu_A, o_alu_B and o_alu_Op SHALL stay stable from their load until the next load; the ALU inputs SHALL NOT change during EXEC or transmit.
REQ-017 i_rx_done in EXEC, TX_RES, WAIT_RES, TX_FLG or WAIT_FLG SHALL pulse o_drop and SHALL NOT change any register.
REQ-018 i_tx_done in any state other than WAIT_RES or WAIT_FLG SHALL be ignored.
REQ-019 i_rx_done and i_tx_done asserted in the same cycle SHALL be handled independently, each per the rules above.
REQ-020 Zero-extension and truncation of bytes SHALL use the low N bits only; no sign-extension SHALL be performed.
REQ-021 The minimum frame turnaround SHALL be: last rx byte -> o_tx_start after ALU_LAT+2 cycles.

Reset
REQ-022 On i_reset, the FSM SHALL go to RX_A.
REQ-023 On i_reset, o_alu_A, o_alu_B, o_alu_Op, o_tx_data and the captured result and flags SHALL clear to 0.
REQ-024 On i_reset, o_tx_start, o_drop and o_busy SHALL clear to 0.
REQ-025 Reset SHALL take priority over all other inputs in the same cycle.
REQ-026 A reset mid-frame or mid-transmit SHALL abandon the frame, and no further o_tx_start SHALL follow it.

Structure
REQ-027 The opcode localparams (ADD..NOR) and the state encoding SHALL live in a shared package/include file used by alu, alu_uart_ctrl and the benches.
REQ-028 The block SHALL contain no sub-module other than an optional opcode-valid function.
REQ-029 The top level SHALL instantiate uart_rx -> alu_uart_ctrl -> alu, with alu_uart_ctrl -> uart_tx for the response.

Verification
REQ-030 The bench SHALL cover: rx 0x05, 0x03, 0x20 (ADD) -> tx 0x08 then 0x00; o_busy high from the 3rd byte until the 2nd i_tx_done.
REQ-031 The bench SHALL cover: rx 0x05, 0x05, 0x22 (SUB) -> tx 0x00 then 0x01 (zero flag).
REQ-032 The bench SHALL cover: rx 0x7F, 0x01, 0x20 (ADD) -> tx 0x80 then 0x02 (overflow flag).
REQ-033 The bench SHALL cover: rx 0x0A, 0x02, 0x3F -> o_drop pulse with no tx; then 0x24 (AND) -> tx 0x02 then 0x00.
REQ-034 The bench SHALL cover: rx byte during WAIT_RES -> o_drop pulse, transmitted bytes unchanged, FSM returns to RX_A after 2 tx.
REQ-035 The bench SHALL cover: i_reset asserted in WAIT_RES -> next cycle all outputs 0, no o_tx_start; a following frame 0x01, 0x01, 0x25 (OR) -> tx 0x01 then 0x00.

Source files
------------

// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the ALU/UART controller, the ALU and the benches.
//   - ALU opcode encodings (low 6 bits of the opcode byte)
//   - controller state encoding
//   - op_valid(): accepts an opcode byte only if [7:6]=00 and [5:0] is a known op
package alu_uart_ctrl_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        RX_A     = 3'd0,
        RX_B     = 3'd1,
        RX_OP    = 3'd2,
        EXEC     = 3'd3,
        TX_RES   = 3'd4,
        WAIT_RES = 3'd5,
        TX_FLG   = 3'd6,
        WAIT_FLG = 3'd7
    } state_t;

    function automatic logic op_valid(input logic [7:0] i_byte);
        if (i_byte[7:6] != 2'b00) begin
            return 1'b0;
        end
        case (i_byte[5:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_ctrl.sv
// Sequencer between a UART receiver/transmitter and an ALU.
// Receives A, B and an opcode byte, waits for the ALU, then transmits the
// result byte followed by a flag byte {6'b0, ovf, zero}.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_rx_data, i_rx_done      received byte + one-cycle valid pulse
//   o_alu_A, o_alu_B, o_alu_Op registered ALU operands / opcode
//   i_alu_Result, i_ovf_flag, i_zero_flag   ALU outputs
//   o_tx_data, o_tx_start     byte to transmitter + one-cycle start pulse
//   i_tx_done                 transmitter finished pulse
//   o_busy                    high in every state except RX_A
//   o_drop                    one-cycle pulse: received byte discarded
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_A     | idle, waiting for operand A
// RX_B     | waiting for operand B
// RX_OP    | waiting for a valid opcode byte (invalid ones are dropped)
// EXEC     | down-counting ALU_LAT..0, capture ALU outputs at zero
// TX_RES   | result byte on o_tx_data, o_tx_start high this cycle
// WAIT_RES | holding result byte until i_tx_done
// TX_FLG   | flag byte on o_tx_data, o_tx_start high this cycle
// WAIT_FLG | holding flag byte until i_tx_done
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int N       = 8,
    parameter int NSel    = 6,
    parameter int ALU_LAT = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_done,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    input  logic [N-1:0]    i_alu_Result,
    input  logic            i_ovf_flag,
    input  logic            i_zero_flag,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_start,
    input  logic            i_tx_done,
    output logic            o_busy,
    output logic            o_drop
);

    localparam int CW = $clog2(ALU_LAT + 1) + 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_alu_A;
    logic [N-1:0]    r_alu_B;
    logic [NSel-1:0] r_alu_Op;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_busy;
    logic            r_drop;
    logic            r_ovf;
    logic            r_zero;

    // The captured result lives directly in r_tx_data: it is zero-extended
    // and loaded on the same edge that enters TX_RES, so the start pulse and
    // the result byte appear together during the TX_RES cycle. This gives a
    // last-rx-byte to o_tx_start turnaround of ALU_LAT+2 cycles.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= RX_A;
            r_cnt      <= '0;
            r_alu_A    <= '0;
            r_alu_B    <= '0;
            r_alu_Op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_drop     <= 1'b0;
            case (r_state)
                RX_A: begin
                    if (i_rx_done) begin
                        r_alu_A <= i_rx_data[N-1:0];
                        r_busy  <= 1'b1;
                        r_state <= RX_B;
                    end
                end
                RX_B: begin
                    if (i_rx_done) begin
                        r_alu_B <= i_rx_data[N-1:0];
                        r_state <= RX_OP;
                    end
                end
                RX_OP: begin
                    if (i_rx_done) begin
                        if (op_valid(i_rx_data)) begin
                            r_alu_Op <= NSel'(i_rx_data[5:0]);
                            r_cnt    <= CW'(ALU_LAT);
                            r_state  <= EXEC;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_drop <= i_rx_done;
                    if (r_cnt == '0) begin
                        r_tx_data  <= 8'(i_alu_Result);
                        r_ovf      <= i_ovf_flag;
                        r_zero     <= i_zero_flag;
                        r_tx_start <= 1'b1;
                        r_state    <= TX_RES;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                TX_RES: begin
                    r_drop  <= i_rx_done;
                    r_state <= WAIT_RES;
                end
                WAIT_RES: begin
                    r_drop <= i_rx_done;
                    if (i_tx_done) begin
                        r_tx_data  <= {6'b0, r_ovf, r_zero};
                        r_tx_start <= 1'b1;
                        r_state    <= TX_FLG;
                    end
                end
                TX_FLG: begin
                    r_drop  <= i_rx_done;
                    r_state <= WAIT_FLG;
                end
                WAIT_FLG: begin
                    r_drop <= i_rx_done;
                    if (i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= RX_A;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= RX_A;
                end
            endcase
        end
    end

    assign o_alu_A    = r_alu_A;
    assign o_alu_B    = r_alu_B;
    assign o_alu_Op   = r_alu_Op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_drop     = r_drop;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a one-cycle-latency behavioural ALU.
module tb_alu_uart_ctrl;
    import alu_uart_ctrl_pkg::*;

    localparam int N       = 8;
    localparam int NSel    = 6;
    localparam int ALU_LAT = 1;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [7:0]      i_rx_data;
    logic            i_rx_done;
    logic [N-1:0]    o_alu_A;
    logic [N-1:0]    o_alu_B;
    logic [NSel-1:0] o_alu_Op;
    logic [N-1:0]    i_alu_Result = '0;
    logic            i_ovf_flag = 1'b0;
    logic            i_zero_flag = 1'b0;
    logic [7:0]      o_tx_data;
    logic            o_tx_start;
    logic            i_tx_done;
    logic            o_busy;
    logic            o_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(.N(N), .NSel(NSel), .ALU_LAT(ALU_LAT)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .o_alu_A      (o_alu_A),
        .o_alu_B      (o_alu_B),
        .o_alu_Op     (o_alu_Op),
        .i_alu_Result (i_alu_Result),
        .i_ovf_flag   (i_ovf_flag),
        .i_zero_flag  (i_zero_flag),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy),
        .o_drop       (o_drop)
    );

    // Behavioural ALU, registered once to model ALU_LAT = 1.
    logic [N-1:0] w_res;
    logic         w_ovf;
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (o_alu_Op)
            OP_ADD: begin
                w_res = o_alu_A + o_alu_B;
                w_ovf = (o_alu_A[N-1] == o_alu_B[N-1]) && (w_res[N-1] != o_alu_A[N-1]);
            end
            OP_SUB: begin
                w_res = o_alu_A - o_alu_B;
                w_ovf = (o_alu_A[N-1] != o_alu_B[N-1]) && (w_res[N-1] != o_alu_A[N-1]);
            end
            OP_AND:  w_res = o_alu_A & o_alu_B;
            OP_OR:   w_res = o_alu_A | o_alu_B;
            OP_XOR:  w_res = o_alu_A ^ o_alu_B;
            OP_NOR:  w_res = ~(o_alu_A | o_alu_B);
            OP_SRA:  w_res = $signed(o_alu_A) >>> o_alu_B[2:0];
            OP_SRL:  w_res = o_alu_A >> o_alu_B[2:0];
            default: w_res = '0;
        endcase
    end
    always @(posedge clk) begin
        i_alu_Result <= w_res;
        i_ovf_flag   <= w_ovf;
        i_zero_flag  <= (w_res == '0);
    end

    task automatic chk8(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    // Waits (bounded) for o_tx_start, checks the byte and the one-cycle pulse.
    task automatic expect_tx(input logic [7:0] exp, input string tag, output int lat);
        lat = 0;
        while (o_tx_start !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk1(o_tx_start, 1'b1, {tag, "_start"});
        chk8(o_tx_data, exp, {tag, "_data"});
        @(negedge clk);
        chk1(o_tx_start, 1'b0, {tag, "_pulse_width"});
        chk8(o_tx_data, exp, {tag, "_hold"});
    endtask

    // Sends the opcode byte of an already started frame and completes both tx bytes.
    task automatic finish_frame(input logic [7:0] op, input logic [7:0] exp_r,
                                input logic [7:0] exp_f, input string tag);
        int lat;
        send_byte(op);
        chk1(o_busy, 1'b1, {tag, "_busy_exec"});
        expect_tx(exp_r, {tag, "_res"}, lat);
        // Measured from the negedge after the opcode cycle: ALU_LAT+2 edges total.
        chk8(8'(lat), 8'(ALU_LAT + 1), {tag, "_turnaround"});
        repeat (2) @(negedge clk);
        chk8(o_tx_data, exp_r, {tag, "_wait_res_hold"});
        chk1(o_busy, 1'b1, {tag, "_busy_wait_res"});
        tx_done_pulse();
        expect_tx(exp_f, {tag, "_flg"}, lat);
        chk1(o_busy, 1'b1, {tag, "_busy_wait_flg"});
        tx_done_pulse();
        chk1(o_busy, 1'b0, {tag, "_idle"});
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp_r, input logic [7:0] exp_f, input string tag);
        send_byte(a);
        chk1(o_busy, 1'b1, {tag, "_busy_rx_b"});
        send_byte(b);
        finish_frame(op, exp_r, exp_f, tag);
    endtask

    initial begin
        int lat;
        int starts;

        // Reset with rx_done/tx_done also asserted: reset must win.
        i_reset   = 1'b1;
        i_rx_data = 8'hAA;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        repeat (3) @(negedge clk);
        chk8(o_alu_A, 8'h00, "rst_alu_A");
        chk8(8'(o_alu_Op), 8'h00, "rst_alu_Op");
        chk8(o_tx_data, 8'h00, "rst_tx_data");
        chk1(o_tx_start, 1'b0, "rst_tx_start");
        chk1(o_busy, 1'b0, "rst_busy");
        chk1(o_drop, 1'b0, "rst_drop");
        i_reset   = 1'b0;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        @(negedge clk);
        chk1(o_busy, 1'b0, "idle_after_reset");

        // ADD 5+3
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, "add");
        chk8(o_alu_A, 8'h05, "add_alu_A_kept");
        chk8(o_alu_B, 8'h03, "add_alu_B_kept");

        // SUB 5-5 -> zero flag
        run_frame(8'h05, 8'h05, 8'h22, 8'h00, 8'h01, "sub_zero");

        // ADD 0x7F+1 -> signed overflow
        run_frame(8'h7F, 8'h01, 8'h20, 8'h80, 8'h02, "add_ovf");

        // Invalid opcode dropped, then AND
        send_byte(8'h0A);
        send_byte(8'h02);
        send_byte(8'h3F);
        chk1(o_drop, 1'b1, "bad_op_drop");
        @(negedge clk);
        chk1(o_drop, 1'b0, "bad_op_drop_width");
        chk8(8'(o_alu_Op), 8'h20, "bad_op_op_unchanged");
        starts = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_tx_start) starts++;
        end
        chk8(8'(starts), 8'd0, "bad_op_no_tx");
        finish_frame(8'h24, 8'h02, 8'h00, "and");

        // NOR 0xF0|0x0F -> 0x00, zero flag
        run_frame(8'hF0, 8'h0F, 8'h27, 8'h00, 8'h01, "nor");

        // XOR with an rx byte arriving in WAIT_RES, then rx+tx done together in WAIT_FLG
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h26);
        expect_tx(8'h07, "xor_res", lat);
        send_byte(8'h55);
        chk1(o_drop, 1'b1, "wait_res_drop");
        chk8(o_tx_data, 8'h07, "wait_res_data_kept");
        chk8(o_alu_A, 8'h03, "wait_res_A_kept");
        chk1(o_tx_start, 1'b0, "wait_res_no_start");
        tx_done_pulse();
        expect_tx(8'h00, "xor_flg", lat);
        @(negedge clk);
        i_rx_data = 8'h99;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        chk1(o_drop, 1'b1, "both_done_drop");
        chk1(o_busy, 1'b0, "both_done_idle");
        chk8(o_alu_A, 8'h03, "both_done_A_kept");

        // Reset in WAIT_RES abandons the frame
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        expect_tx(8'h30, "pre_reset_res", lat);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk8(o_alu_A, 8'h00, "mid_rst_A");
        chk8(o_alu_B, 8'h00, "mid_rst_B");
        chk8(8'(o_alu_Op), 8'h00, "mid_rst_Op");
        chk8(o_tx_data, 8'h00, "mid_rst_tx_data");
        chk1(o_tx_start, 1'b0, "mid_rst_tx_start");
        chk1(o_busy, 1'b0, "mid_rst_busy");
        chk1(o_drop, 1'b0, "mid_rst_drop");
        starts = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_tx_start) starts++;
        end
        chk8(8'(starts), 8'd0, "mid_rst_no_tx");

        // OR frame after reset
        run_frame(8'h01, 8'h01, 8'h25, 8'h01, 8'h00, "or");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
